// File: rtl/branch_resolve.sv
// Branch resolution stage: evaluates issued conditional branches against the recorded prediction
// and emits a tag free or a mispredict flush. Optional counters under BRANCH_RESOLVE_PERF_EN.
module branch_resolve #(
  parameter int BNUM = 4
`ifdef BRANCH_RESOLVE_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        BranchWorkEn,
  input  logic [31:0] operandO,
  input  logic [31:0] operandT,
  input  logic [31:0] imm,
  input  logic [2:0]  opCode,
  input  logic [31:0] PC,
  input  logic [1:0]  bNum,
  input  logic        predEn,
  input  logic [1:0]  predNum,
  input  logic        predTaken,
  output logic        bFreeEn,
  output logic [1:0]  bFreeNum,
  output logic        misTaken,
  output logic [31:0] redirectPC,
  output logic        bhtEn,
  output logic [31:0] bhtPC,
  output logic        bhtTaken
`ifdef BRANCH_RESOLVE_PERF_EN
  , output logic [PERF_W-1:0] perfResolved
  , output logic [PERF_W-1:0] perfMiss
`endif
);

  // Opcodes follow the RISC-V funct3 encoding; 3'b010 and 3'b011 resolve as not-taken.
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  logic [BNUM-1:0] valid;
  logic [BNUM-1:0] taken;
  logic            actual;
  logic            resolve;
  logic            mismatch;
  logic [31:0]     target;

  always_comb begin
    actual = 1'b0;
    case (opCode)
      BEQ:     actual = (operandO == operandT);
      BNE:     actual = (operandO != operandT);
      BLT:     actual = ($signed(operandO) <  $signed(operandT));
      BGE:     actual = ($signed(operandO) >= $signed(operandT));
      BLTU:    actual = (operandO <  operandT);
      BGEU:    actual = (operandO >= operandT);
      default: actual = 1'b0;
    endcase
  end

  assign target   = actual ? (PC + imm) : (PC + 32'd4);
  assign resolve  = BranchWorkEn && valid[bNum];
  assign mismatch = resolve && (actual != taken[bNum]);

  // A same-tag record lands after the free (later NBA wins); a flush drops it,
  // as does any record arriving while the flush pulse is out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      taken <= '0;
    end else if (mismatch) begin
      valid <= '0;
    end else begin
      if (resolve) valid[bNum] <= 1'b0;
      if (predEn && !misTaken) begin
        valid[predNum] <= 1'b1;
        taken[predNum] <= predTaken;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bFreeEn    <= 1'b0;
      bFreeNum   <= 2'd0;
      misTaken   <= 1'b0;
      redirectPC <= 32'd0;
      bhtEn      <= 1'b0;
      bhtPC      <= 32'd0;
      bhtTaken   <= 1'b0;
    end else begin
      bFreeEn  <= resolve && !mismatch;
      misTaken <= mismatch;
      bhtEn    <= resolve;
      if (resolve) begin
        bhtPC    <= PC;
        bhtTaken <= actual;
      end
      if (resolve && !mismatch) bFreeNum <= bNum;
      if (mismatch) redirectPC <= target;
    end
  end

`ifdef BRANCH_RESOLVE_PERF_EN
  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfResolved <= '0;
      perfMiss     <= '0;
    end else begin
      if (resolve && (perfResolved != '1)) perfResolved <= perfResolved + PERF_W'(1);
      if (mismatch && (perfMiss != '1))    perfMiss     <= perfMiss + PERF_W'(1);
    end
  end
`endif

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution stage directly downstream of the branch reservation station. It consumes one issued conditional branch per cycle, evaluates the condition, and compares the outcome with the prediction the front end recorded for that branch tag. It produces either a tag-free broadcast (correct prediction) or a mispredict flush with a redirect PC. It also drives the branch-history update port.

## Interface
- Parameters:
- `BNUM`, 4, branch tags in flight; fixed to the 2-bit `bNum` space.
- `PERF_W`, 32, width of the performance counters (only with `BRANCH_RESOLVE_PERF_EN`).
- Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `BranchWorkEn`  in  1  issued branch is valid this cycle.
- `operandO`, `operandT`  in  `DataBus`  rs1 and rs2 values.
- `imm`  in  `DataBus`  sign-extended branch offset.
- `opCode`  in  `OpBus`  one of `BEQ`, `BNE`, `BLT`, `BGE`, `BLTU`, `BGEU`.
- `PC`  in  `InstAddrBus`  branch instruction address.
- `bNum`  in  2  branch tag of the issued branch.
- `predEn`  in  1  front end records a prediction.
- `predNum`  in  2  tag being recorded.
- `predTaken`  in  1  predicted direction.
- `bFreeEn`  out  1  correct resolution; release tag `bFreeNum`.
- `bFreeNum`  out  2  tag released.
- `misTaken`  out  1  mispredict flush pulse.
- `redirectPC`  out  `InstAddrBus`  correct fetch address when `misTaken`.
- `bhtEn`  out  1  history update valid.
- `bhtPC`  out  `InstAddrBus`  PC to update.
- `bhtTaken`  out  1  actual direction.
- `perfResolved`, `perfMiss`  out  `PERF_W`  counters (only with `BRANCH_RESOLVE_PERF_EN`).

## Operation
- **Prediction table**: `BNUM` entries, each holding `valid` and `taken`.
  - `predEn` sets `valid[predNum]` and writes `taken[predNum] = predTaken`.
- **Condition evaluation**:
  - `BEQ`/`BNE`: equality of `operandO` and `operandT`.
  - `BLT`/`BGE`: signed compare.
  - `BLTU`/`BGEU`: unsigned compare.
  - Any other opcode is treated as not-taken.
- **Target**:
  - Taken: `PC + imm`.
  - Not-taken: `PC + 4`.
  - 32-bit arithmetic, wrap-around modulo 2^32; no overflow flag.
- **Resolution** (`BranchWorkEn=1` and `valid[bNum]=1`):
  - Mismatch (`actual != taken[bNum]`): `misTaken=1`, `redirectPC` = target, `bFreeEn=0`, and every table entry is cleared.
  - Match: `bFreeEn=1`, `bFreeNum=bNum`, `misTaken=0`, and `valid[bNum]` is cleared.
  - Either case: `bhtEn=1`, `bhtPC=PC`, `bhtTaken=actual`.
- **Invalid tag**: `BranchWorkEn=1` with `valid[bNum]=0` is ignored. No outputs assert and no table change.
- **Write during flush**: `predEn` is ignored in the cycle `misTaken` is high. That cycle is the flush edge seen by the reservation station and the dispatcher.
- **Same-tag resolve and record in one cycle** (`predNum == bNum`):
  - Resolution uses the old entry.
  - The new record is written after the free, so the entry ends valid.
  - Exception: on a mismatch, the clear wins and the new record is dropped.

## Timing
- **Latency**: inputs sampled at edge N; all outputs registered and valid during cycle N+1.
- **Pulse width**: `misTaken`, `bFreeEn` and `bhtEn` are single-cycle pulses; they deassert at N+2 unless a new branch resolves.
- **Issue rate**: one branch per cycle, back-to-back, no stall or backpressure.
- **Reset values**: all table entries invalid and all outputs 0, including `bFreeNum`, `redirectPC`, `bhtPC`, `bhtTaken`, and the counters.
- **Reset mid-operation**: a pending pulse is dropped; nothing asserts in the cycle after `rst` falls.

## Configuration
- **`BRANCH_RESOLVE_PERF_EN` defined**:
  - `perfResolved` increments on every valid resolution.
  - `perfMiss` increments on every mispredict.
  - Both saturate at all-ones and are cleared only by `rst`.
- **Not defined**: both counter ports are absent and the counter logic is not synthesised; all other behaviour is identical.

## Test plan
- **Correct taken**: record tag 1 with `predTaken=1`; issue `BEQ`, operands 5/5, `PC=0x100`, `imm=0x20`. Next cycle: `bFreeEn=1`, `bFreeNum=1`, `misTaken=0`, `bhtTaken=1`, `bhtPC=0x100`.
- **Mispredict**: record tag 2 with `predTaken=1`; issue `BLT`, operands 3/-1, `PC=0x200`. Next cycle: `misTaken=1`, `redirectPC=0x204`, all entries invalid; a following issue on tag 0 produces no outputs.
- **Signed vs unsigned**: issue `BLTU` with operands 0xFFFFFFFF/1, `predTaken=0` → correct, `bhtTaken=0`; issue `BLT` with the same operands, `predTaken=0` → `misTaken=1`, target `PC+imm`.
- **Wrap-around**: `PC=0xFFFFFFF0`, `imm=0x20`, taken, predicted not-taken → `redirectPC=0x00000010`.
- **Same-tag collision and flush priority**:
  - Resolve tag 3 correctly while `predEn` records tag 3 → tag 3 stays valid.
  - Repeat with a mismatch → tag 3 invalid.
  - `predEn` asserted during the `misTaken` cycle → ignored.
- **Reset and counters**: assert `rst` while `bFreeEn` is pending → all outputs 0. With `BRANCH_RESOLVE_PERF_EN`, 3 resolutions including 1 miss → `perfResolved=3`, `perfMiss=1`.
